// File: rtl/imem_pkg.sv
// Shared types and constants for the parametrised instruction memory.
// Fault codes, the NOP word and the default pipeline stage record.
package imem_pkg;

    typedef logic [1:0] fault_t;

    localparam fault_t FAULT_NONE     = 2'b00;
    localparam fault_t FAULT_MISALIGN = 2'b01;
    localparam fault_t FAULT_RANGE    = 2'b10;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // Record carried down the read pipeline (32-bit default width).
    typedef struct packed {
        logic        valid;
        fault_t      fault;
        logic [31:0] data;
    } imem_stage_t;

endpackage

// File: rtl/imem_delay_line.sv
// Register chain of read-pipeline records with sync clear and flush.
// DEPTH = 0 degenerates to a plain wire-through.
module imem_delay_line
    import imem_pkg::*;
#(
    parameter int  DEPTH   = 0,
    parameter type stage_t = imem_stage_t
) (
    input  logic   clock,
    input  logic   reset_n,
    input  logic   flush,
    input  stage_t d,
    output stage_t q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = &{1'b0, clock, reset_n, flush};
            assign q = d;
        end else begin : g_regs
            stage_t chain [DEPTH];

            // Shift one stage per cycle; reset and flush empty every stage.
            always_ff @(posedge clock) begin
                if (!reset_n || flush) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        chain[i] <= '0;
                    end
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end

            assign q = chain[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/instruction_memory_param.sv
// Parametrised instruction memory with valid/ready fetch, fault codes,
// flush for branch redirects and a program-load write port.
module instruction_memory_param
    import imem_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 32,
    parameter int    DEPTH_WORDS  = 256,
    parameter int    READ_LATENCY = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] read_address,
    input  logic                  flush,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [1:0]            fault,
    input  logic                  load_enable,
    input  logic [ADDR_WIDTH-1:0] load_address,
    input  logic [DATA_WIDTH-1:0] load_data
);

    localparam int OFF_BITS = $clog2(DATA_WIDTH / 8);
    localparam int IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
        ADDR_WIDTH'((1 << OFF_BITS) - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A =
        ADDR_WIDTH'(DEPTH_WORDS);

    typedef struct packed {
        logic                  valid;
        fault_t                fault;
        logic [DATA_WIDTH-1:0] data;
    } stage_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] ld_idx;
    fault_t           rd_fault;
    fault_t           ld_fault;
    logic             accept;
    stage_t           cap;
    stage_t           out_rec;

    // Misalignment and range are independent; both bits may be set.
    function automatic fault_t addr_fault(
        input logic [ADDR_WIDTH-1:0] addr
    );
        fault_t f;
        f = FAULT_NONE;
        if ((addr & OFF_MASK) != '0) begin
            f = f | FAULT_MISALIGN;
        end
        if ((addr >> OFF_BITS) >= DEPTH_A) begin
            f = f | FAULT_RANGE;
        end
        return f;
    endfunction

    assign rd_idx   = IDX_W'(read_address >> OFF_BITS);
    assign ld_idx   = IDX_W'(load_address >> OFF_BITS);
    assign rd_fault = addr_fault(read_address);
    assign ld_fault = addr_fault(load_address);

    // Loads own the array for their cycle, so reads back off.
    assign req_ready = reset_n && !load_enable;
    assign accept    = req_valid && req_ready;

    // First stage: array read on the accepting edge, NOP for faults.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cap <= '0;
        end else if (accept) begin
            cap.valid <= 1'b1;
            cap.fault <= rd_fault;
            cap.data  <= (rd_fault == FAULT_NONE) ? mem[rd_idx]
                                                 : DATA_WIDTH'(NOP_WORD);
        end else begin
            cap <= '0;
        end
    end

    // Program-load port; bad addresses are dropped, contents survive reset.
    always_ff @(posedge clock) begin
        if (reset_n && load_enable && ld_fault == FAULT_NONE) begin
            mem[ld_idx] <= load_data;
        end
    end

    imem_delay_line #(
        .DEPTH   (READ_LATENCY - 1),
        .stage_t (stage_t)
    ) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (flush),
        .d       (cap),
        .q       (out_rec)
    );

    assign resp_valid  = out_rec.valid;
    assign instruction = out_rec.data;
    assign fault       = out_rec.fault;

endmodule

// File: tb/tb_instruction_memory_param.sv
// Bench for instruction_memory_param: three latencies driven in parallel,
// checked against a due-cycle response model plus literal expectations.
module tb_instruction_memory_param;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic [31:0] read_address;
    logic        flush;
    logic        load_enable;
    logic [31:0] load_address;
    logic [31:0] load_data;

    logic        rdy [3];
    logic        rv  [3];
    logic [31:0] ins [3];
    logic [1:0]  flt [3];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int          lat;
        int          due;
        logic [31:0] data;
        logic [1:0]  fault;
    } exp_t;

    exp_t        pend [$];
    logic [31:0] mmem [int];

    always #5 clk = ~clk;

    instruction_memory_param #(.READ_LATENCY(1)) u_l1 (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(rdy[0]),
        .read_address(read_address), .flush(flush),
        .resp_valid(rv[0]), .instruction(ins[0]), .fault(flt[0]),
        .load_enable(load_enable), .load_address(load_address),
        .load_data(load_data)
    );

    instruction_memory_param #(.READ_LATENCY(2)) u_l2 (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(rdy[1]),
        .read_address(read_address), .flush(flush),
        .resp_valid(rv[1]), .instruction(ins[1]), .fault(flt[1]),
        .load_enable(load_enable), .load_address(load_address),
        .load_data(load_data)
    );

    instruction_memory_param #(.READ_LATENCY(3)) u_l3 (
        .clock(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(rdy[2]),
        .read_address(read_address), .flush(flush),
        .resp_valid(rv[2]), .instruction(ins[2]), .fault(flt[2]),
        .load_enable(load_enable), .load_address(load_address),
        .load_data(load_data)
    );

    function automatic logic [1:0] model_fault(input logic [31:0] a);
        logic [1:0] f;
        f = 2'b00;
        if (a % 4 != 0) f[0] = 1'b1;
        if (a / 4 >= 256) f[1] = 1'b1;
        return f;
    endfunction

    // Model: schedule each accepted fetch for every latency.
    initial forever begin
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            pend.delete();
        end else begin
            if (flush) pend.delete();
            if (req_valid && !load_enable) begin
                for (int l = 1; l <= 3; l++) begin
                    e.lat   = l;
                    e.due   = cyc + l - 1;
                    e.fault = model_fault(read_address);
                    if (e.fault != 2'b00) e.data = 32'h0;
                    else e.data = mmem[int'(read_address / 4)];
                    pend.push_back(e);
                end
            end
            if (load_enable && model_fault(load_address) == 2'b00)
                mmem[int'(load_address / 4)] = load_data;
        end
    end

    // Compare every DUT against the model once per cycle.
    initial forever begin
        logic        ev;
        logic [31:0] ed;
        logic [1:0]  ef;
        @(negedge clk);
        if (cyc > 0) begin
            for (int l = 1; l <= 3; l++) begin
                ev = 1'b0;
                ed = 32'h0;
                ef = 2'b00;
                foreach (pend[i]) begin
                    if (pend[i].lat == l && pend[i].due == cyc) begin
                        ev = 1'b1;
                        ed = pend[i].data;
                        ef = pend[i].fault;
                    end
                end
                total++;
                if ({rv[l-1], ins[l-1], flt[l-1]} !== {ev, ed, ef}) begin
                    bad++;
                    $display("FAIL resp_L%0d cyc=%0d: got v=%b d=%h f=%b want v=%b d=%h f=%b",
                             l, cyc, rv[l-1], ins[l-1], flt[l-1], ev, ed, ef);
                end
            end
            for (int i = pend.size() - 1; i >= 0; i--) begin
                if (pend[i].due <= cyc) pend.delete(i);
            end
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        load_enable  = 1'b1;
        load_address = a;
        load_data    = d;
        tick();
        load_enable  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        req_valid    = 1'b1;
        read_address = a;
        tick();
        req_valid    = 1'b0;
    endtask

    initial begin
        reset_n      = 1'b0;
        req_valid    = 1'b1;
        read_address = 32'h0;
        flush        = 1'b0;
        load_enable  = 1'b0;
        load_address = 32'h0;
        load_data    = 32'h0;
        #1;
        chk("ready_in_reset", 32'(rdy[0]), 32'h0);
        tick();
        tick();
        chk("reset_rv1", 32'(rv[0]), 32'h0);
        chk("reset_rv3", 32'(rv[2]), 32'h0);
        chk("reset_ins1", ins[0], 32'h0);
        reset_n   = 1'b1;
        req_valid = 1'b0;

        do_load(32'h0,   32'h2008_0005);
        do_load(32'h4,   32'h2009_0007);
        do_load(32'h8,   32'h200A_0009);
        do_load(32'hC,   32'h012A_5820);
        do_load(32'h6,   32'h1111_1111);
        do_load(32'h400, 32'h2222_2222);

        fetch(32'h4);
        chk("l1_fetch4_v", 32'(rv[0]), 32'h1);
        chk("l1_fetch4_d", ins[0], 32'h2009_0007);
        chk("l1_fetch4_f", 32'(flt[0]), 32'h0);
        repeat (4) tick();

        req_valid = 1'b1; read_address = 32'h0; tick();
        read_address = 32'h4; tick();
        read_address = 32'h8; tick();
        req_valid = 1'b0;
        chk("l3_b2b_0_v", 32'(rv[2]), 32'h1);
        chk("l3_b2b_0", ins[2], 32'h2008_0005);
        tick();
        chk("l3_b2b_1", ins[2], 32'h2009_0007);
        tick();
        chk("l3_b2b_2", ins[2], 32'h200A_0009);
        tick();
        chk("l3_b2b_end", 32'(rv[2]), 32'h0);

        fetch(32'h2);
        chk("mis_f", 32'(flt[0]), 32'h1);
        chk("mis_d", ins[0], 32'h0);
        fetch(32'h400);
        chk("rng_f", 32'(flt[0]), 32'h2);
        fetch(32'h402);
        chk("both_f", 32'(flt[0]), 32'h3);
        fetch(32'h0);
        chk("rng_load_dropped", ins[0], 32'h2008_0005);
        repeat (3) tick();

        load_enable  = 1'b1;
        load_address = 32'h4;
        load_data    = 32'hDEAD_BEEF;
        req_valid    = 1'b1;
        read_address = 32'h4;
        #1;
        chk("ready_on_load", 32'(rdy[0]), 32'h0);
        tick();
        load_enable = 1'b0;
        chk("no_resp_on_load", 32'(rv[0]), 32'h0);
        tick();
        req_valid = 1'b0;
        chk("new_word_v", 32'(rv[0]), 32'h1);
        chk("new_word", ins[0], 32'hDEAD_BEEF);
        repeat (3) tick();

        req_valid = 1'b1; read_address = 32'h0; tick();
        flush = 1'b1; read_address = 32'h8; tick();
        flush = 1'b0; req_valid = 1'b0;
        chk("l2_flushed", 32'(rv[1]), 32'h0);
        chk("l1_target", ins[0], 32'h200A_0009);
        tick();
        chk("l2_target_v", 32'(rv[1]), 32'h1);
        chk("l2_target", ins[1], 32'h200A_0009);
        tick();
        chk("l2_after", 32'(rv[1]), 32'h0);
        repeat (2) tick();

        req_valid = 1'b1; read_address = 32'hC; tick();
        req_valid = 1'b0; flush = 1'b1; tick();
        flush = 1'b0;
        tick();
        chk("l3_flush_only", 32'(rv[2]), 32'h0);
        repeat (4) tick();

        req_valid = 1'b1; read_address = 32'h0; tick();
        read_address = 32'hC; tick();
        req_valid = 1'b0; reset_n = 1'b0; tick();
        reset_n = 1'b1;
        chk("rst_l2", 32'(rv[1]), 32'h0);
        chk("rst_l3", 32'(rv[2]), 32'h0);
        tick();
        chk("rst_l3_b", 32'(rv[2]), 32'h0);
        fetch(32'hC);
        chk("after_rst_c", ins[0], 32'h012A_5820);
        fetch(32'h0);
        chk("after_rst_0", ins[0], 32'h2008_0005);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
